// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester channels and the single downstream memory port.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and answers the memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction read channel
    logic              inst_rden;
    logic [AW-1:0]     inst_raddr;
    logic              inst_cancel;
    logic              inst_rvalid;
    logic [DW-1:0]     inst_rdata;

    // Data read channel
    logic              data_rden;
    logic [AW-1:0]     data_raddr;
    logic              data_rvalid;
    logic [DW-1:0]     data_rdata;

    // Data write channel
    logic              data_wren;
    logic [AW-1:0]     data_waddr;
    logic [DW/8-1:0]   data_wstrb;
    logic [DW-1:0]     data_wdata;
    logic              data_wdone;

    // Downstream memory port
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW/8-1:0]   mem_strb;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ack;
    logic [DW-1:0]     mem_rdata;
    logic              mem_wait;

    modport slave (
        input  inst_rden, inst_raddr, inst_cancel,
        output inst_rvalid, inst_rdata,
        input  data_rden, data_raddr,
        output data_rvalid, data_rdata,
        input  data_wren, data_waddr, data_wstrb, data_wdata,
        output data_wdone,
        output mem_req, mem_we, mem_addr, mem_strb, mem_wdata, mem_wait,
        input  mem_ack, mem_rdata
    );

    modport master (
        output inst_rden, inst_raddr, inst_cancel,
        input  inst_rvalid, inst_rdata,
        output data_rden, data_raddr,
        input  data_rvalid, data_rdata,
        output data_wren, data_waddr, data_wstrb, data_wdata,
        input  data_wdone,
        input  mem_req, mem_we, mem_addr, mem_strb, mem_wdata, mem_wait,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for a single-outstanding memory port.
// Priority write > data read > inst read, with a saturating streak counter that
// forces an inst grant after STARVE_LIMIT data grants made while fetch waited.
// A flush during an in-flight fetch lets the access finish but hides its result.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4      // legal range 1..15 (4-bit streak counter)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    mem_port_arbiter_if.slave   bus
);
    localparam int          SW    = DW / 8;
    localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY_IR,
        ST_BUSY_DR,
        ST_BUSY_DW,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic              cancel_q, cancel_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [SW-1:0]     mem_strb_q, mem_strb_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;

    logic              inst_rvalid_q, inst_rvalid_d;
    logic [DW-1:0]     inst_rdata_q, inst_rdata_d;
    logic              data_rvalid_q, data_rvalid_d;
    logic [DW-1:0]     data_rdata_q, data_rdata_d;
    logic              data_wdone_q, data_wdone_d;

    logic              inst_ok;

    // A fetch is only eligible when it is not being flushed this cycle.
    assign inst_ok = bus.inst_rden & ~bus.inst_cancel;

    // Next-state, grant selection, issue capture and completion handling.
    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        cancel_d      = cancel_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_strb_d    = mem_strb_q;
        mem_wdata_d   = mem_wdata_q;
        inst_rvalid_d = 1'b0;
        inst_rdata_d  = inst_rdata_q;
        data_rvalid_d = 1'b0;
        data_rdata_d  = data_rdata_q;
        data_wdone_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cancel_d = 1'b0;

                if (inst_ok && (streak_q == LIMIT)) begin
                    state_d = ST_BUSY_IR;
                end else if (bus.data_wren) begin
                    state_d = ST_BUSY_DW;
                end else if (bus.data_rden) begin
                    state_d = ST_BUSY_DR;
                end else if (inst_ok) begin
                    state_d = ST_BUSY_IR;
                end

                // Streak counts data grants that overtook a waiting fetch.
                if ((state_d == ST_BUSY_IR) || !bus.inst_rden) begin
                    streak_d = 4'd0;
                end else if ((state_d != ST_IDLE) && (streak_q < LIMIT)) begin
                    streak_d = streak_q + 4'd1;
                end

                // Capture the granted request onto the memory port.
                case (state_d)
                    ST_BUSY_IR: begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.inst_raddr;
                        mem_strb_d  = '1;
                        mem_wdata_d = '0;
                    end
                    ST_BUSY_DR: begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.data_raddr;
                        mem_strb_d  = '1;
                        mem_wdata_d = '0;
                    end
                    ST_BUSY_DW: begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = bus.data_waddr;
                        mem_strb_d  = bus.data_wstrb;
                        mem_wdata_d = bus.data_wdata;
                    end
                    default: ;
                endcase
            end

            ST_BUSY_IR: begin
                if (bus.inst_cancel) begin
                    cancel_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                    // A flush seen at any point of the access (including the
                    // ack cycle) discards the returned instruction.
                    if (!(cancel_q || bus.inst_cancel)) begin
                        inst_rvalid_d = 1'b1;
                        inst_rdata_d  = bus.mem_rdata;
                    end
                end
            end

            ST_BUSY_DR: begin
                if (bus.mem_ack) begin
                    mem_req_d     = 1'b0;
                    state_d       = ST_DONE;
                    data_rvalid_d = 1'b1;
                    data_rdata_d  = bus.mem_rdata;
                end
            end

            ST_BUSY_DW: begin
                if (bus.mem_ack) begin
                    mem_req_d    = 1'b0;
                    state_d      = ST_DONE;
                    data_wdone_d = 1'b1;
                end
            end

            ST_DONE: begin
                cancel_d = 1'b0;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops an in-progress request at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            streak_q      <= 4'd0;
            cancel_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_strb_q    <= '0;
            mem_wdata_q   <= '0;
            inst_rvalid_q <= 1'b0;
            inst_rdata_q  <= '0;
            data_rvalid_q <= 1'b0;
            data_rdata_q  <= '0;
            data_wdone_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            cancel_q      <= cancel_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_strb_q    <= mem_strb_d;
            mem_wdata_q   <= mem_wdata_d;
            inst_rvalid_q <= inst_rvalid_d;
            inst_rdata_q  <= inst_rdata_d;
            data_rvalid_q <= data_rvalid_d;
            data_rdata_q  <= data_rdata_d;
            data_wdone_q  <= data_wdone_d;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_strb    = mem_strb_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_wait    = (state_q != ST_IDLE);
    assign bus.inst_rvalid = inst_rvalid_q;
    assign bus.inst_rdata  = inst_rdata_q;
    assign bus.data_rvalid = data_rvalid_q;
    assign bus.data_rdata  = data_rdata_q;
    assign bus.data_wdone  = data_wdone_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters, a small memory
// responder with random ack latency, and a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_DONE = 2;

    localparam int K_NONE = 0;
    localparam int K_IR   = 1;
    localparam int K_DR   = 2;
    localparam int K_DW   = 3;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (transaction level)
    int          ph;
    int          kind;
    int          streak;
    bit          m_cancel;
    int          ack_wait;
    bit          hold_ack;
    bit          e_req, e_we, e_irv, e_drv, e_wd;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    logic [3:0]  e_strb;
    logic [31:0] mem_arr [8];

    // Stimulus probabilities (percent)
    int p_ir, p_dr, p_dw, p_cancel, p_stray;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rnd(input int p);
        return (int'($urandom_range(0, 99)) < p);
    endfunction

    task automatic model_reset();
        ph = M_IDLE; kind = K_NONE; streak = 0; m_cancel = 0; ack_wait = 0;
        e_req = 0; e_we = 0; e_irv = 0; e_drv = 0; e_wd = 0;
        e_addr = '0; e_wdata = '0; e_strb = '0; e_irdata = '0; e_drdata = '0;
    endtask

    // Compute what the arbiter must do on the coming edge from the driven inputs.
    task automatic model_advance();
        bit inst_ok;
        int g;
        int idx;
        e_irv = 0; e_drv = 0; e_wd = 0;
        if (ph == M_IDLE) begin
            inst_ok = bus.inst_rden && !bus.inst_cancel;
            g = K_NONE;
            if (inst_ok && streak == LIMIT) g = K_IR;
            else if (bus.data_wren)         g = K_DW;
            else if (bus.data_rden)         g = K_DR;
            else if (inst_ok)               g = K_IR;
            if (g == K_IR || !bus.inst_rden) streak = 0;
            else if (g != K_NONE)            streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
            if (g != K_NONE) begin
                ph = M_BUSY; kind = g; m_cancel = 0; e_req = 1;
                ack_wait = int'($urandom_range(0, 3));
                if (g == K_IR) begin
                    e_addr = bus.inst_raddr; e_we = 0; e_strb = 4'hF;
                end else if (g == K_DR) begin
                    e_addr = bus.data_raddr; e_we = 0; e_strb = 4'hF;
                end else begin
                    e_addr = bus.data_waddr; e_we = 1; e_strb = bus.data_wstrb;
                    e_wdata = bus.data_wdata;
                end
            end
        end else if (ph == M_BUSY) begin
            if (kind == K_IR && bus.inst_cancel) m_cancel = 1;
            if (bus.mem_ack) begin
                e_req = 0;
                ph = M_DONE;
                if (kind == K_IR) begin
                    if (!m_cancel) begin e_irv = 1; e_irdata = bus.mem_rdata; end
                end else if (kind == K_DR) begin
                    e_drv = 1; e_drdata = bus.mem_rdata;
                end else begin
                    e_wd = 1;
                    idx = int'(e_addr[4:2]);
                    for (int b = 0; b < 4; b++)
                        if (e_strb[b]) mem_arr[idx][8*b +: 8] = e_wdata[8*b +: 8];
                end
            end
        end else begin
            ph = M_IDLE;
        end
    endtask

    task automatic check_outputs();
        check_eq("mem_req",    64'(bus.mem_req), 64'(e_req));
        check_eq("mem_wait",   64'(bus.mem_wait), 64'(ph != M_IDLE));
        check_eq("pulses",     64'({bus.inst_rvalid, bus.data_rvalid, bus.data_wdone}),
                               64'({e_irv, e_drv, e_wd}));
        check_eq("inst_rdata", 64'(bus.inst_rdata), 64'(e_irdata));
        check_eq("data_rdata", 64'(bus.data_rdata), 64'(e_drdata));
        if (e_req) begin
            check_eq("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
            check_eq("mem_we",   64'(bus.mem_we),   64'(e_we));
            check_eq("mem_strb", 64'(bus.mem_strb), 64'(e_strb));
            if (e_we) check_eq("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
        end
    endtask

    // One cycle: check, update requesters and memory, advance model, next negedge.
    task automatic step();
        check_outputs();
        if (e_irv) bus.inst_rden = 0;
        else if (!bus.inst_rden && rnd(p_ir)) begin
            bus.inst_rden = 1; bus.inst_raddr = $urandom & 32'hFFFF_FFFC;
        end
        if (e_drv) bus.data_rden = 0;
        else if (!bus.data_rden && rnd(p_dr)) begin
            bus.data_rden = 1; bus.data_raddr = $urandom & 32'hFFFF_FFFC;
        end
        if (e_wd) bus.data_wren = 0;
        else if (!bus.data_wren && rnd(p_dw)) begin
            bus.data_wren  = 1;
            bus.data_waddr = $urandom & 32'hFFFF_FFFC;
            bus.data_wstrb = 4'($urandom_range(1, 15));
            bus.data_wdata = $urandom;
        end
        bus.inst_cancel = 0;
        if (rnd(p_cancel)) begin
            bus.inst_cancel = 1; bus.inst_rden = 0;
        end
        bus.mem_ack   = 0;
        bus.mem_rdata = $urandom;
        if (ph == M_BUSY) begin
            if (!hold_ack) begin
                if (ack_wait == 0) begin
                    bus.mem_ack = 1;
                    if (!e_we) bus.mem_rdata = mem_arr[int'(e_addr[4:2])];
                end else begin
                    ack_wait--;
                end
            end
        end else if (rnd(p_stray)) begin
            bus.mem_ack = 1;
        end
        model_advance();
        @(negedge clk);
    endtask

    task automatic set_probs(input int ir, input int dr, input int dw, input int cn, input int st);
        p_ir = ir; p_dr = dr; p_dw = dw; p_cancel = cn; p_stray = st;
    endtask

    int phase_tab [4][5] = '{
        '{ 30,  30,  30,  5, 10},   // balanced mix
        '{100, 100,   0,  0,  0},   // fetch held, data always re-raised: starvation
        '{ 20,  10, 100, 10, 20},   // write heavy, back-to-back writes
        '{ 60,  60,  60, 15,  5}    // dense contention with flushes
    };

    initial begin
        rst_n = 0;
        bus.inst_rden = 0; bus.inst_raddr = '0; bus.inst_cancel = 0;
        bus.data_rden = 0; bus.data_raddr = '0;
        bus.data_wren = 0; bus.data_waddr = '0; bus.data_wstrb = '0; bus.data_wdata = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        hold_ack = 0;
        for (int i = 0; i < 8; i++) mem_arr[i] = $urandom;
        model_reset();
        set_probs(0, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_req",  64'(bus.mem_req), 64'd0);
        check_eq("rst_mem_wait", 64'(bus.mem_wait), 64'd0);
        check_eq("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check_eq("rst_mem_strb", 64'(bus.mem_strb), 64'd0);
        check_eq("rst_pulses",   64'({bus.inst_rvalid, bus.data_rvalid, bus.data_wdone}), 64'd0);
        check_eq("rst_rdata",    64'({bus.inst_rdata, bus.data_rdata}), 64'd0);
        rst_n = 1;

        // Reset in the middle of a data read with ack withheld
        hold_ack = 1;
        set_probs(0, 100, 0, 0, 0);
        for (int i = 0; i < 20 && !(ph == M_BUSY && kind == K_DR); i++) step();
        check_eq("dr_grant_seen", 64'(ph == M_BUSY && kind == K_DR), 64'd1);
        step(); step();
        #2 rst_n = 0;
        #1;
        check_eq("async_rst_req",  64'(bus.mem_req), 64'd0);
        check_eq("async_rst_wait", 64'(bus.mem_wait), 64'd0);
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        bus.data_rden = 0;
        @(negedge clk);
        check_eq("rst_stray_rvalid", 64'(bus.data_rvalid), 64'd0);
        rst_n = 1;
        hold_ack = 0;
        model_reset();
        set_probs(0, 0, 0, 0, 0);
        model_advance();            // stray ack while idle must be ignored
        @(negedge clk);

        // Randomized phases
        for (int p = 0; p < 4; p++) begin
            set_probs(phase_tab[p][0], phase_tab[p][1], phase_tab[p][2],
                      phase_tab[p][3], phase_tab[p][4]);
            repeat (600) step();
        end

        // Drain
        set_probs(0, 0, 0, 0, 0);
        repeat (30) step();
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
